// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges buffered ALU results and priority load responses onto the register-file write port
module writeback_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR       = 5,
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_alu_valid,
    output logic                              o_alu_ready,
    input  logic [REG_ADDR-1:0]               i_alu_rd,
    input  logic [DATA_WIDTH-1:0]             i_alu_data,
    input  logic                              i_ld_valid,
    output logic                              o_ld_ready,
    input  logic [REG_ADDR-1:0]               i_ld_rd,
    input  logic [2:0]                        i_ld_funct3,
    input  logic [1:0]                        i_ld_byte_off,
    input  logic [DATA_WIDTH-1:0]             i_ld_rdata,
    output logic                              o_wr_reg_en,
    output logic [REG_ADDR-1:0]               o_write_register_addr,
    output logic [DATA_WIDTH-1:0]             o_write_data,
    output logic                              o_ld_err,
    output logic [$clog2(ALU_FIFO_DEPTH):0]   o_fifo_count
);
    localparam int PW = $clog2(ALU_FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   FULL = (PW + 1)'(ALU_FIFO_DEPTH);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    logic [REG_ADDR-1:0]   rd_mem   [ALU_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [ALU_FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, off;
    logic [PW:0]           count;
    logic [SW-1:0]         starve;
    logic                  hazard, ld_grant, pop, push, ld_illegal;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_WIDTH-1:0] ld_data;

    // WAW hazard: an older, still-queued ALU write targets the load's destination
    always_comb begin
        hazard = 1'b0;
        off    = '0;
        for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ({1'b0, off} < count && rd_mem[i] == i_ld_rd && i_ld_rd != '0) hazard = 1'b1;
        end
    end

    assign o_alu_ready  = count < FULL;
    assign o_ld_ready   = !hazard && starve != SLIM;
    assign ld_grant     = i_ld_valid && o_ld_ready;
    assign pop          = !ld_grant && count != '0;
    assign push         = i_alu_valid && o_alu_ready;
    assign o_fifo_count = count;

    // Load byte/half/word extraction with sign or zero extension
    always_comb begin
        ld_illegal = 1'b0;
        byte_v     = i_ld_rdata[8*i_ld_byte_off +: 8];
        half_v     = i_ld_rdata[16*i_ld_byte_off[1] +: 16];
        case (i_ld_funct3)
            3'b000:  ld_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            3'b001:  ld_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
            3'b010:  ld_data = i_ld_rdata;
            default: begin
                ld_data    = '0;
                ld_illegal = 1'b1;
            end
        endcase
    end

    // FIFO storage; contents are don't-care once pointers reset
    always_ff @(posedge i_clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= i_alu_rd;
            data_mem[wr_ptr] <= i_alu_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Starve counter: counts loads beating a full FIFO, saturating to force a pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) starve <= '0;
        else if (pop || count != FULL) starve <= '0;
        else if (ld_grant && starve != SLIM) starve <= starve + 1'b1;
    end

    // Registered write stage; address/data hold when nothing is granted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_reg_en           <= 1'b0;
            o_write_register_addr <= '0;
            o_write_data          <= '0;
            o_ld_err              <= 1'b0;
        end else begin
            o_wr_reg_en <= ld_grant ? i_ld_rd != '0 : pop && rd_mem[rd_ptr] != '0;
            o_ld_err    <= ld_grant && ld_illegal;
            if (ld_grant) begin
                o_write_register_addr <= i_ld_rd;
                o_write_data          <= ld_data;
            end else if (pop) begin
                o_write_register_addr <= rd_mem[rd_ptr];
                o_write_data          <= data_mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed stimulus with a queued scoreboard checked by an independent write-port monitor
module tb_writeback_arbiter;
    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic        i_alu_valid = 1'b0, o_alu_ready;
    logic [4:0]  i_alu_rd = '0;
    logic [31:0] i_alu_data = '0;
    logic        i_ld_valid = 1'b0, o_ld_ready;
    logic [4:0]  i_ld_rd = '0;
    logic [2:0]  i_ld_funct3 = '0;
    logic [1:0]  i_ld_byte_off = '0;
    logic [31:0] i_ld_rdata = '0;
    logic        o_wr_reg_en, o_ld_err;
    logic [4:0]  o_write_register_addr;
    logic [31:0] o_write_data;
    logic [1:0]  o_fifo_count;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t sbq[$];
    int vectors = 0, miscompares = 0;

    writeback_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
        .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
        .i_ld_rd(i_ld_rd), .i_ld_funct3(i_ld_funct3),
        .i_ld_byte_off(i_ld_byte_off), .i_ld_rdata(i_ld_rdata),
        .o_wr_reg_en(o_wr_reg_en), .o_write_register_addr(o_write_register_addr),
        .o_write_data(o_write_data), .o_ld_err(o_ld_err),
        .o_fifo_count(o_fifo_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input logic e);
        exp_t x;
        x.a = a;
        x.d = d;
        x.e = e;
        sbq.push_back(x);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        i_ld_valid    = 1'b1;
        i_ld_rd       = rd;
        i_ld_funct3   = f3;
        i_ld_byte_off = off;
        i_ld_rdata    = d;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_alu_valid = v;
        i_alu_rd    = rd;
        i_alu_data  = d;
    endtask

    // Monitor: every visible write or error pulse must match the oldest expected write
    always @(negedge i_clk) begin
        if (i_rst_n && (o_wr_reg_en || o_ld_err)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_write", {26'd0, o_wr_reg_en, o_write_register_addr}, 32'd0);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("wr_en", {31'd0, o_wr_reg_en}, 32'd1);
                chk("wr_addr", {27'd0, o_write_register_addr}, {27'd0, x.a});
                chk("wr_data", o_write_data, x.d);
                chk("ld_err", {31'd0, o_ld_err}, {31'd0, x.e});
            end
        end
    end

    logic [2:0]  lf3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
    logic [1:0]  loff[6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0};
    logic [31:0] lexp[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01, 32'h0};

    initial begin
        #2;
        chk("rst_alu_ready", {31'd0, o_alu_ready}, 32'd1);
        chk("rst_ld_ready", {31'd0, o_ld_ready}, 32'd1);
        chk("rst_wr_en", {31'd0, o_wr_reg_en}, 32'd0);
        chk("rst_count", {30'd0, o_fifo_count}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("idle_wr_en", {31'd0, o_wr_reg_en}, 32'd0);
        chk("idle_alu_ready", {31'd0, o_alu_ready}, 32'd1);
        chk("idle_ld_ready", {31'd0, o_ld_ready}, 32'd1);
        chk("idle_count", {30'd0, o_fifo_count}, 32'd0);

        // single uncontended ALU write
        alu(1'b1, 5'd5, 32'h1234_5678);
        expect_wr(5'd5, 32'h1234_5678, 1'b0);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        chk("alu_count1", {30'd0, o_fifo_count}, 32'd1);
        tick();
        tick();

        // load extraction
        for (int i = 0; i < 6; i++) begin
            ld(5'(10 + i), lf3[i], loff[i], 32'h80FF_7F01);
            #1;
            chk("ld_ready_extract", {31'd0, o_ld_ready}, 32'd1);
            expect_wr(5'(10 + i), lexp[i], i == 5);
            tick();
        end
        i_ld_valid = 1'b0;
        tick();

        // WAW: load to rd 7 waits for the queued ALU write to rd 7
        alu(1'b1, 5'd7, 32'hA);
        expect_wr(5'd7, 32'hA, 1'b0);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        ld(5'd7, 3'b010, 2'd0, 32'hB);
        #1;
        chk("waw_blocked", {31'd0, o_ld_ready}, 32'd0);
        tick();
        chk("waw_released", {31'd0, o_ld_ready}, 32'd1);
        expect_wr(5'd7, 32'hB, 1'b0);
        tick();
        i_ld_valid = 1'b0;
        tick();

        // starvation: full FIFO loses four times, then is forced
        alu(1'b1, 5'd20, 32'h20);
        ld(5'd1, 3'b010, 2'd0, 32'h101);
        expect_wr(5'd1, 32'h101, 1'b0);
        tick();
        alu(1'b1, 5'd21, 32'h21);
        ld(5'd2, 3'b010, 2'd0, 32'h102);
        #1;
        chk("starve_fill_ready", {31'd0, o_alu_ready}, 32'd1);
        expect_wr(5'd2, 32'h102, 1'b0);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        chk("starve_full", {30'd0, o_fifo_count}, 32'd2);
        for (int r = 3; r <= 6; r++) begin
            ld(5'(r), 3'b010, 2'd0, 32'h100 + r);
            #1;
            chk("starve_ld_ready", {31'd0, o_ld_ready}, 32'd1);
            expect_wr(5'(r), 32'h100 + r, 1'b0);
            tick();
        end
        ld(5'd7, 3'b010, 2'd0, 32'h107);
        #1;
        chk("starve_forced", {31'd0, o_ld_ready}, 32'd0);
        chk("starve_count2", {30'd0, o_fifo_count}, 32'd2);
        expect_wr(5'd20, 32'h20, 1'b0);
        tick();
        chk("starve_cleared", {31'd0, o_ld_ready}, 32'd1);
        chk("starve_count1", {30'd0, o_fifo_count}, 32'd1);
        expect_wr(5'd7, 32'h107, 1'b0);
        tick();
        i_ld_valid = 1'b0;
        expect_wr(5'd21, 32'h21, 1'b0);
        tick();
        tick();

        // rd 0 from both sources, push+pop at count 1, ready low at count 2
        alu(1'b1, 5'd0, 32'h55);
        ld(5'd0, 3'b010, 2'd0, 32'hDEAD_0000);
        tick();
        chk("x0_ld_en", {31'd0, o_wr_reg_en}, 32'd0);
        chk("x0_ld_addr", {27'd0, o_write_register_addr}, 32'd0);
        chk("x0_ld_data", o_write_data, 32'hDEAD_0000);
        alu(1'b1, 5'd9, 32'h99);
        ld(5'd0, 3'b010, 2'd0, 32'hBEEF);
        #1;
        chk("x0_ready_c1", {31'd0, o_alu_ready}, 32'd1);
        tick();
        chk("x0_count2", {30'd0, o_fifo_count}, 32'd2);
        i_ld_valid = 1'b0;
        alu(1'b1, 5'd0, 32'h77);
        #1;
        chk("x0_ready_full", {31'd0, o_alu_ready}, 32'd0);
        tick();
        chk("x0_count_pop", {30'd0, o_fifo_count}, 32'd1);
        chk("x0_alu_en", {31'd0, o_wr_reg_en}, 32'd0);
        chk("x0_alu_data", o_write_data, 32'h55);
        expect_wr(5'd9, 32'h99, 1'b0);
        tick();
        chk("x0_pushpop_count", {30'd0, o_fifo_count}, 32'd1);
        alu(1'b0, 5'd0, 32'd0);
        tick();
        chk("x0_drain_count", {30'd0, o_fifo_count}, 32'd0);
        chk("x0_drain_data", o_write_data, 32'h77);
        chk("x0_drain_en", {31'd0, o_wr_reg_en}, 32'd0);

        // reset mid-operation discards the queued entry
        alu(1'b1, 5'd3, 32'h33);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        chk("mid_count", {30'd0, o_fifo_count}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_count", {30'd0, o_fifo_count}, 32'd0);
        chk("mid_rst_en", {31'd0, o_wr_reg_en}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        tick();

        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
